alu_serial_exec: RTL

Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller together with two operands and produces a registered result.
Logic, arithmetic, compare and branch-compare ops complete in one cycle. Shifts run through an iterative 1-bit-per-cycle shifter, so shift area stays minimal.
The block uses valid/ready handshakes on both sides, so the pipeline control can stall around multi-cycle shifts.

---
 rtl/alu_exec_pkg.sv | 59 +++++
 rtl/alu_serial_shifter.sv | 72 +++++++
 rtl/alu_serial_exec.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types for the serial execute-stage ALU: op codes, FSM states and
// small decode helpers used by the top level and the shifter.
package alu_exec_pkg;

  // ALU operation codes delivered by the ALU controller.
  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SLL = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_BNE = 4'b1001,
    OP_SLT = 4'b1100,
    OP_SRA = 4'b1110,
    OP_SRL = 4'b1111
  } alu_op_t;

  // Execute FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } exec_state_t;

  // True for the ops that go through the iterative shifter.
  function automatic logic is_shift(input alu_op_t op);
    logic r;
    case (op)
      OP_SLL:  r = 1'b1;
      OP_SRL:  r = 1'b1;
      OP_SRA:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // True when the shift moves bits towards the MSB.
  function automatic logic is_left_shift(input alu_op_t op);
    logic r;
    case (op)
      OP_SLL:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // True when vacated MSBs are filled with the sign bit.
  function automatic logic is_arith_shift(input alu_op_t op);
    logic r;
    case (op)
      OP_SRA:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative 1-bit-per-cycle shifter. load captures the source, amount and
// direction; each step moves acc by one bit and decrements cnt. done tells
// the controller that cnt will be zero after this cycle's update, and
// acc_nxt is the value acc takes at that same edge, so the final result can
// be registered without waiting an extra cycle.
module alu_serial_shifter
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [SHAMT_W-1:0]    load_shamt,
  input  alu_op_t               load_op,
  output logic [DATA_WIDTH-1:0] acc_nxt,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d;
  logic                  left_q, left_d;
  logic                  arith_q, arith_d;
  logic                  fill_bit;

  // Next-state for accumulator, counter and direction control.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    arith_d  = arith_q;
    fill_bit = arith_q & acc_q[DATA_WIDTH-1];
    if (load) begin
      acc_d   = load_data;
      cnt_d   = load_shamt;
      left_d  = is_left_shift(load_op);
      arith_d = is_arith_shift(load_op);
    end else if (step) begin
      if (left_q) begin
        acc_d = {acc_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {fill_bit, acc_q[DATA_WIDTH-1:1]};
      end
      cnt_d = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Shifter state registers; reset discards any in-flight shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= {DATA_WIDTH{1'b0}};
      cnt_q   <= {SHAMT_W{1'b0}};
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

  assign acc_nxt = acc_d;
  assign done    = (cnt_d == {SHAMT_W{1'b0}});

endmodule

// File: rtl/alu_serial_exec.sv
// Execute-stage ALU with valid/ready on both sides. Single-cycle ops are
// computed at accept; shifts are handed to the iterative shifter. The result
// and Zero flag sit in output registers and are held while in DONE until
// downstream takes them.
module alu_serial_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  exec_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;

  alu_op_t               op_in;
  logic                  accept;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  sh_load;
  logic                  sh_step;
  logic                  sh_done;
  logic [DATA_WIDTH-1:0] sh_acc_nxt;

  assign op_in    = alu_op_t'(Operation);
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;

  // Single-cycle datapath: logic, wrap-around add/sub and compares.
  always_comb begin
    alu_res = {DATA_WIDTH{1'b0}};
    case (op_in)
      OP_AND:  alu_res = SrcA & SrcB;
      OP_OR:   alu_res = SrcA | SrcB;
      OP_XOR:  alu_res = SrcA ^ SrcB;
      OP_ADD:  alu_res = SrcA + SrcB;
      OP_SUB:  alu_res = SrcA - SrcB;
      OP_BEQ:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_BNE:  alu_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: alu_res = {DATA_WIDTH{1'b0}};
    endcase
  end

  // FSM next state, shifter control and output-register updates.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    sh_load  = 1'b0;
    sh_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift(op_in)) begin
            sh_load = 1'b1;
            if (sh_done) begin
              // Zero shift amount: the source passes straight through.
              state_d  = DONE;
              result_d = sh_acc_nxt;
              zero_d   = (sh_acc_nxt == {DATA_WIDTH{1'b0}});
            end else begin
              state_d = SHIFT;
            end
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == {DATA_WIDTH{1'b0}});
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sh_step = 1'b1;
        if (sh_done) begin
          state_d  = DONE;
          result_d = sh_acc_nxt;
          zero_d   = (sh_acc_nxt == {DATA_WIDTH{1'b0}});
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= {DATA_WIDTH{1'b0}};
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  alu_serial_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_W    (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (sh_load),
    .step       (sh_step),
    .load_data  (SrcA),
    .load_shamt (SrcB[SHAMT_W-1:0]),
    .load_op    (op_in),
    .acc_nxt    (sh_acc_nxt),
    .done       (sh_done)
  );

  assign out_valid = (state_q == DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule
